// File: rtl/ad1xx_mon_pkg.sv
// Shared types and sizing helpers for the ad1xx run monitor.
package ad1xx_mon_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } mon_state_t;

  localparam int DEFAULT_XLEN   = 32;
  localparam int BYTES_PER_WORD = DEFAULT_XLEN / 8;

  // Width of dump_index: one spare bit so DUMP_WORDS itself is representable.
  function automatic int index_width(input int words);
    return $clog2(words) + 1;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/halt_dump_monitor_loop_detector.sv
// Self-loop detector: counts consecutive retirements of an identical {pc, inst}
// and pulses when the run length reaches HALT_REPEATS.
module loop_detector
  import ad1xx_mon_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int HALT_REPEATS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            retire,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output logic            halted_pulse
);

  localparam int CW = count_width(HALT_REPEATS + 1);

  logic            seen_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [CW-1:0]   count_q;
  logic            match;

  assign match = seen_q && (pc == pc_q) && (inst == inst_q);

  // Combinational so the halt is registered on the same edge as the final retire.
  assign halted_pulse = enable && retire && match &&
                        (count_q >= CW'(HALT_REPEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q  <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      count_q <= '0;
    end else if (enable && retire) begin
      seen_q <= 1'b1;
      if (match) begin
        if (count_q != CW'(HALT_REPEATS)) count_q <= count_q + 1'b1;
      end else begin
        count_q <= CW'(1);
        pc_q    <= pc;
        inst_q  <= inst;
      end
    end
  end

endmodule

// File: rtl/halt_dump_monitor.sv
// Run monitor: detects halt or timeout on the retire stream, then dumps a
// window of byte-wide RAM as little-endian words over a valid/ready port.
module halt_dump_monitor
  import ad1xx_mon_pkg::*;
#(
  parameter int XLEN           = DEFAULT_XLEN,
  parameter int ADDR_W         = 16,
  parameter int HALT_REPEATS   = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DUMP_BASE      = 0,
  parameter int DUMP_WORDS     = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 retire,
  input  logic [XLEN-1:0]                      pc,
  input  logic [XLEN-1:0]                      inst,
  output logic                                 mem_req,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic                                 mem_ack,
  input  logic [7:0]                           mem_rdata,
  output logic                                 dump_valid,
  input  logic                                 dump_ready,
  output logic [index_width(DUMP_WORDS)-1:0]   dump_index,
  output logic [XLEN-1:0]                      dump_data,
  output logic                                 halted,
  output logic                                 timed_out,
  output logic                                 done,
  output logic [31:0]                          cycle_count
);

  localparam int BPW = XLEN / 8;
  localparam int BW  = count_width(BPW);
  localparam int IW  = index_width(DUMP_WORDS);

  mon_state_t      state_q;
  mon_state_t      next_state;
  logic [BW-1:0]   byte_q;
  logic [IW-1:0]   word_q;
  logic [XLEN-1:0] asm_q;

  logic halt_pulse;
  logic timeout_hit;
  logic last_byte;
  logic last_word;
  logic set_halt;
  logic set_timeout;
  logic take_byte;
  logic accept;

  loop_detector #(
    .XLEN         (XLEN),
    .HALT_REPEATS (HALT_REPEATS)
  ) u_loop (
    .clk          (clk),
    .rst          (reset),
    .enable       (state_q == ST_RUN),
    .retire       (retire),
    .pc           (pc),
    .inst         (inst),
    .halted_pulse (halt_pulse)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cycle_count == 32'(TIMEOUT_CYCLES - 1));
  assign last_byte   = (byte_q == BW'(BPW - 1));
  assign last_word   = (word_q == IW'(DUMP_WORDS - 1));

  // Address wraps modulo 2^ADDR_W; driven only while a byte fetch is in flight.
  assign mem_addr = (state_q == ST_REQ || state_q == ST_WAIT)
                  ? ADDR_W'(DUMP_BASE) + ADDR_W'(word_q) * ADDR_W'(BPW) + ADDR_W'(byte_q)
                  : '0;

  assign dump_data  = asm_q;
  assign dump_index = word_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state  = state_q;
    mem_req     = 1'b0;
    dump_valid  = 1'b0;
    done        = 1'b0;
    set_halt    = 1'b0;
    set_timeout = 1'b0;
    take_byte   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Halt has priority over a coincident timeout.
        if (halt_pulse) begin
          set_halt   = 1'b1;
          next_state = ST_REQ;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          next_state  = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req    = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          take_byte  = 1'b1;
          next_state = last_byte ? ST_OUT : ST_REQ;
        end
      end
      ST_OUT: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          accept     = 1'b1;
          next_state = last_word ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_q      <= '0;
      word_q      <= '0;
      asm_q       <= '0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (state_q == ST_RUN && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (set_halt)    halted    <= 1'b1;
      if (set_timeout) timed_out <= 1'b1;
      if (take_byte) begin
        asm_q[8*byte_q +: 8] <= mem_rdata;
        if (!last_byte) byte_q <= byte_q + 1'b1;
      end
      if (accept) begin
        byte_q <= '0;
        if (!last_word) word_q <= word_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_halt_dump_monitor.sv
// Scoreboard bench for halt_dump_monitor: scripted and random retire streams,
// a RAM responder with variable ack latency, and monitors that pop expectations.
module tb_halt_dump_monitor;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 16;
  localparam int HR     = 4;
  localparam int TO     = 50;
  localparam int BASE   = 0;
  localparam int WORDS  = 4;
  localparam int BPW    = XLEN / 8;
  localparam int IW     = $clog2(WORDS) + 1;

  typedef struct { logic r; logic [31:0] pc; logic [31:0] inst; } ret_t;
  typedef struct { logic [IW-1:0] idx; logic [31:0] data; } word_t;
  typedef struct { logic h; logic t; logic [31:0] cc; } stat_t;

  logic              clk, reset, retire;
  logic [XLEN-1:0]   pc, inst;
  logic              mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              dump_valid, dump_ready;
  logic [IW-1:0]     dump_index;
  logic [XLEN-1:0]   dump_data;
  logic              halted, timed_out, done;
  logic [31:0]       cycle_count;

  halt_dump_monitor #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .HALT_REPEATS(HR), .TIMEOUT_CYCLES(TO),
    .DUMP_BASE(BASE), .DUMP_WORDS(WORDS)
  ) dut (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .inst(inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_index(dump_index),
    .dump_data(dump_data), .halted(halted), .timed_out(timed_out), .done(done),
    .cycle_count(cycle_count)
  );

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] addr_q [$];
  word_t             word_q [$];
  stat_t             stat_q [$];

  int n_vec = 0;
  int n_err = 0;
  int fixed_lat = 1;
  int stall_cnt = 0;
  bit stall_req = 0;
  bit ready_rand = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // RAM responder: one outstanding byte read, ack 1..3 cycles after the request.
  initial begin
    logic [ADDR_W-1:0] a;
    int lat;
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        a = mem_addr;
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
        repeat (lat - 1) @(posedge clk);
        @(posedge clk);
        #1;
        if (!reset) begin
          mem_ack = 1;
          mem_rdata = ram[a];
          @(posedge clk);
          #1;
          mem_ack = 0;
        end
      end
    end
  end

  // Consumer: optional 10-cycle stall on the first word, else random or always ready.
  initial begin
    dump_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        dump_ready = 0;
        stall_cnt--;
      end else if (stall_req && dump_valid) begin
        stall_req = 0;
        stall_cnt = 9;
        dump_ready = 0;
      end else begin
        dump_ready = ready_rand ? (($urandom % 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops expected addresses, words and final status as the DUT presents them.
  initial begin
    logic prev_v, prev_r, prev_req, prev_done;
    logic [XLEN-1:0] prev_d;
    logic [IW-1:0] prev_i;
    word_t w;
    stat_t s;
    prev_v = 0; prev_r = 0; prev_req = 0; prev_done = 0; prev_d = 0; prev_i = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 0; prev_r = 0; prev_req = 0; prev_done = 0;
      end else begin
        if (mem_req) begin
          check("req_one_cycle", prev_req, 0);
          check("req_expected", addr_q.size() != 0, 1);
          if (addr_q.size() != 0) check("mem_addr", mem_addr, addr_q.pop_front());
        end
        if (prev_v && !prev_r) begin
          check("stall_valid", dump_valid, 1);
          check("stall_data", dump_data, prev_d);
          check("stall_index", dump_index, prev_i);
        end
        if (dump_valid && dump_ready) begin
          check("word_expected", word_q.size() != 0, 1);
          if (word_q.size() != 0) begin
            w = word_q.pop_front();
            check("dump_index", dump_index, w.idx);
            check("dump_data", dump_data, w.data);
          end
        end
        if (done && !prev_done) begin
          check("status_expected", stat_q.size() != 0, 1);
          if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            check("halted", halted, s.h);
            check("timed_out", timed_out, s.t);
            check("cycle_count", cycle_count, s.cc);
          end
          check("words_left", word_q.size(), 0);
          check("addrs_left", addr_q.size(), 0);
          check("done_valid", dump_valid, 0);
        end
        prev_req = mem_req; prev_v = dump_valid; prev_r = dump_ready;
        prev_d = dump_data; prev_i = dump_index; prev_done = done;
      end
    end
  end

  // mode: 0 spec halt, 1 counter restart, 2 timeout, 3 halt/timeout tie,
  //       4 random stream, 5 halt then reset in WAIT on byte 2
  task automatic run_episode(input int mode);
    ret_t  script [$];
    ret_t  ent;
    logic [63:0] last, v;
    bit    have, stop, h, t;
    int    run, c, k;
    logic [31:0] wd;
    logic [ADDR_W-1:0] a;

    reset = 1;
    retire = 0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_index", dump_index, 0);
    check("rst_dump_data", dump_data, 0);
    check("rst_halted", halted, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_done", done, 0);
    check("rst_cycle_count", cycle_count, 0);
    addr_q.delete(); word_q.delete(); stat_q.delete();
    stall_cnt = 0;
    fixed_lat = (mode == 0) ? 1 : (mode == 5) ? 3 : 0;
    stall_req = (mode == 0);
    ready_rand = (mode != 0 && mode != 5);

    for (int i = 0; i < WORDS * BPW; i++) ram[ADDR_W'(BASE + i)] = 8'($urandom);
    if (mode == 0) begin
      ram[ADDR_W'(BASE)] = 8'h78; ram[ADDR_W'(BASE + 1)] = 8'h56;
      ram[ADDR_W'(BASE + 2)] = 8'h34; ram[ADDR_W'(BASE + 3)] = 8'h12;
    end
    for (int w = 0; w < WORDS; w++) begin
      wd = 0;
      for (int b = 0; b < BPW; b++) begin
        a = ADDR_W'(BASE + w * BPW + b);
        addr_q.push_back(a);
        wd = wd | (32'(ram[a]) << (8 * b));
      end
      word_q.push_back('{idx: IW'(w), data: wd});
    end

    case (mode)
      0, 5: begin
        script.push_back('{r: 1, pc: 32'h0, inst: 32'h13});
        script.push_back('{r: 1, pc: 32'h4, inst: 32'h13});
        script.push_back('{r: 1, pc: 32'h8, inst: 32'h13});
        for (int i = 0; i < 4; i++) script.push_back('{r: 1, pc: 32'hC, inst: 32'h6F});
      end
      1: begin
        for (int i = 0; i < 8; i++) begin
          k = $urandom_range(0, 2);
          for (int j = 0; j < k; j++) script.push_back('{r: 0, pc: 32'(j), inst: 32'h0});
          script.push_back('{r: 1, pc: (i == 3) ? 32'h10 : 32'hC, inst: 32'h6F});
        end
      end
      2: for (int i = 0; i < 60; i++) script.push_back('{r: 1, pc: 32'(4 * i), inst: 32'h13});
      3: begin
        for (int i = 0; i < TO - HR; i++) script.push_back('{r: 0, pc: 32'h0, inst: 32'h0});
        for (int i = 0; i < HR; i++) script.push_back('{r: 1, pc: 32'h20, inst: 32'h6F});
      end
      default: for (int i = 0; i < 60; i++)
        script.push_back('{r: 1'($urandom), pc: ($urandom % 2) ? 32'h104 : 32'h100, inst: 32'h6F});
    endcase

    repeat (4) @(posedge clk);
    #1;
    reset = 0;
    c = 0; stop = 0; have = 0; run = 0; last = 0;
    while (!stop && c < 200) begin
      ent = (c < script.size()) ? script[c] : '{r: 0, pc: 32'h0, inst: 32'h0};
      retire = ent.r; pc = ent.pc; inst = ent.inst;
      v = {ent.pc, ent.inst};
      if (ent.r) begin
        if (have && v == last) run = (run < HR) ? run + 1 : HR;
        else begin
          run = 1;
          last = v;
        end
        have = 1;
      end
      h = ent.r && (run == HR);
      t = !h && (c == TO - 1);
      if (h || t) begin
        stat_q.push_back('{h: h, t: t, cc: 32'(c + 1)});
        stop = 1;
      end else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    @(posedge clk);
    #1;
    retire = 0;

    if (mode == 0) begin
      @(negedge clk);
      check("halted_next_cycle", halted, 1);
      k = 0;
      while (!dump_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("first_word_latency", k, 2 * BPW);
    end
    if (mode == 5) begin
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (mem_req && mem_addr == ADDR_W'(BASE + 2)) break;
      end
      check("abort_point_addr", mem_addr, ADDR_W'(BASE + 2));
      @(posedge clk);
      #1;
      return;
    end

    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk);
      #1;
      retire = 1'($urandom);
      pc = 32'hC;
      inst = 32'h6F;
    end
    check("done_reached", done, 1);
    retire = 0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int modes [12] = '{0, 1, 2, 3, 5, 0, 4, 4, 4, 4, 4, 4};
    reset = 1; retire = 0; pc = 0; inst = 0;
    for (int e = 0; e < 12; e++) run_episode(modes[e]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/halt_dump_monitor.md
Name: halt_dump_monitor

Overview:
- Synthesizable run monitor for ad1xx CPU integration and regression.
- Watches the retire stream and declares a halt once the core sits in a self-loop, or declares a timeout after a cycle budget.
- Then reads a parametrised window of byte-wide RAM, assembles it into little-endian words and streams the words out over a valid/ready port.
- Sits beside the core and the RAM; it replaces cycle-polling bench logic.

Parameters:
- XLEN, 32, width of PC, instruction and dump words; multiple of 8.
- ADDR_W, 16, RAM byte-address width.
- HALT_REPEATS, 4, consecutive retirements at an identical PC and instruction that constitute a halt; at least 2.
- TIMEOUT_CYCLES, 100000, cycles in RUN before a forced timeout; 0 disables the timeout.
- DUMP_BASE, 0, byte address of dump word 0.
- DUMP_WORDS, 4, number of XLEN-bit words dumped; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- retire  in  1  one-cycle strobe: the instruction at pc retired.
- pc  in  XLEN  PC of the retired instruction.
- inst  in  XLEN  retired instruction word.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_W  byte address.
- mem_ack  in  1  read data valid; may arrive ≥1 cycle after mem_req.
- mem_rdata  in  8  read byte.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word.
- dump_index  out  $clog2(DUMP_WORDS)+1  index of the current word.
- dump_data  out  XLEN  assembled word.
- halted  out  1  sticky: halt detected.
- timed_out  out  1  sticky: timeout hit.
- done  out  1  sticky: dump complete.
- cycle_count  out  32  cycles spent in RUN; saturates at 2^32-1.

Behaviour:
- Reset (async assert, synchronous release) values: state RUN; all outputs 0; repeat counter 0; stored PC/instruction 0, with a first-retire flag cleared.
- States: RUN, REQ, WAIT, OUT, DONE.
- RUN
  - cycle_count increments every cycle.
  - On retire:
    - if the first-retire flag is set and {pc,inst} equals the stored value, the repeat counter increments (saturating at HALT_REPEATS);
    - otherwise the counter loads 1 and the new {pc,inst} is stored.
    - The flag sets on every retire.
  - Halt: the counter reaches HALT_REPEATS. Set halted and go to REQ on the next edge.
  - Timeout: TIMEOUT_CYCLES≠0 and cycle_count == TIMEOUT_CYCLES-1 with no halt this cycle. Set timed_out and go to REQ.
  - Halt and timeout in the same cycle: halt wins; timed_out stays 0.
  - Retires outside RUN are ignored.
- REQ
  - Assert mem_req for exactly one cycle.
  - mem_addr = DUMP_BASE + word*(XLEN/8) + byte, truncated modulo 2^ADDR_W (wrap allowed).
  - Go to WAIT.
- WAIT
  - Hold mem_addr and keep mem_req low.
  - On mem_ack, place mem_rdata at bits [8*byte+7 : 8*byte] of the assembly register (little-endian).
  - If byte == XLEN/8-1, go to OUT; otherwise increment byte and go to REQ.
  - A mem_ack outside WAIT is ignored.
- OUT
  - dump_valid = 1; dump_data and dump_index stay stable until accepted.
  - On dump_valid && dump_ready: clear byte.
    - If word == DUMP_WORDS-1, go to DONE.
    - Otherwise increment word and go to REQ.
  - Holding dump_ready low stalls indefinitely with no data change.
- DONE
  - done = 1; dump_valid = 0; no memory traffic.
  - Terminal until reset.
- Latency per word with a 1-cycle mem_ack: 2·(XLEN/8) cycles to reach OUT, plus the handshake cycle.
- Reset mid-dump aborts immediately. Any partial word is discarded and the next run restarts the dump from word 0.

Decomposition:
- Package ad1xx_mon_pkg:
  - state enum (RUN, REQ, WAIT, OUT, DONE);
  - localparam BYTES_PER_WORD = XLEN/8;
  - index-width helper function.
- Sub-module loop_detector (retire/pc/inst in; halted_pulse out; parameter HALT_REPEATS) holds the compare-and-count logic. Everything else lives in the top module.

Test Plan:
- Halt detection:
  - Stimulus: retires at PCs 0x0, 0x4 and 0x8, then four retires at pc=0xC with inst=0x0000006F.
  - Response: halted=1 the cycle after the 4th, timed_out=0, cycle_count frozen.
- Counter restart:
  - Stimulus: retires at 0xC, 0xC, 0xC, 0x10, then 0xC ×3.
  - Response: no halt yet; a 4th retire at 0xC raises halted.
- Dump assembly:
  - Stimulus: halt, then RAM bytes 0..3 = 0x78, 0x56, 0x34, 0x12; mem_ack latency 1; dump_ready=1.
  - Response: dump_data=0x12345678 at dump_index=0; mem_addr sequence 0,1,2,3.
  - Done rises after DUMP_WORDS words.
- Timeout and tie-break:
  - Stimulus: TIMEOUT_CYCLES=50 with PC always changing.
  - Response: timed_out=1 at cycle 50 and the dump proceeds.
  - Stimulus: forced simultaneous halt and timeout.
  - Response: only halted is set.
- Backpressure and latency:
  - Stimulus: dump_ready low for 10 cycles in OUT; mem_ack delayed 3 cycles.
  - Response: dump_data stable, no extra mem_req pulses, correct word afterwards.
- Reset mid-dump:
  - Stimulus: assert reset while in WAIT on byte 2, then re-run to halt.
  - Response: all outputs 0 at reset; the second dump starts at mem_addr=DUMP_BASE.
